// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared Y86 constants for the memory-access stage:
//                icodes, status codes, the "no register" id, data widths,
//                and small icode classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_WORD  = 32;
    localparam int c_PCLEN = 32;

    // Memory-touching instruction codes
    localparam logic [3:0] c_IRMMOVL = 4'h4;
    localparam logic [3:0] c_IMRMOVL = 4'h5;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHL  = 4'hA;
    localparam logic [3:0] c_IPOPL   = 4'hB;

    localparam logic [3:0] c_RNONE = 4'hF;

    // Y86 status codes
    localparam logic [2:0] c_SAOK = 3'd1;
    localparam logic [2:0] c_SHLT = 3'd2;
    localparam logic [2:0] c_SADR = 3'd3;
    localparam logic [2:0] c_SINS = 3'd4;

    // True for any instruction that performs a data-memory access
    function automatic logic isMemOp(input logic [3:0] icode);
        return (icode == c_IRMMOVL) || (icode == c_IMRMOVL) ||
               (icode == c_ICALL)   || (icode == c_IRET)    ||
               (icode == c_IPUSHL)  || (icode == c_IPOPL);
    endfunction

    // True for the memory instructions that read (the rest write)
    function automatic logic isReadOp(input logic [3:0] icode);
        return (icode == c_IMRMOVL) || (icode == c_IRET) || (icode == c_IPOPL);
    endfunction

    // popl/ret take their address from valA (old %esp); all others from valE
    function automatic logic addrFromValA(input logic [3:0] icode);
        return (icode == c_IRET) || (icode == c_IPOPL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_wb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb
//  Description : MEM/WB pipeline register. A load pulse captures one result
//                and raises valid for exactly one cycle; without a load the
//                fields hold and valid falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld,
    input  logic [3:0]        i_icode,
    input  logic [2:0]        i_stat,
    input  logic [c_WORD-1:0] i_valE,
    input  logic [c_WORD-1:0] i_valM,
    input  logic [3:0]        i_dstE,
    input  logic [3:0]        i_dstM,
    output logic              o_valid,
    output logic [3:0]        o_icode,
    output logic [2:0]        o_stat,
    output logic [c_WORD-1:0] o_valE,
    output logic [c_WORD-1:0] o_valM,
    output logic [3:0]        o_dstE,
    output logic [3:0]        o_dstM
);

    // Result register: fields load on i_ld, valid is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_icode <= 4'h0;
            o_stat  <= c_SAOK;
            o_valE  <= '0;
            o_valM  <= '0;
            o_dstE  <= c_RNONE;
            o_dstM  <= c_RNONE;
        end else begin
            o_valid <= i_ld;
            if (i_ld) begin
                o_icode <= i_icode;
                o_stat  <= i_stat;
                o_valE  <= i_valE;
                o_valM  <= i_valM;
                o_dstE  <= i_dstE;
                o_dstM  <= i_dstM;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Y86 memory-access stage. Issues data-bus reads/writes over a
//                req/ack interface, stalls ex_mem while a transfer is open,
//                registers results for writeback and freezes after the first
//                non-AOK status.
//  Config      : MEM_TIMEOUT_EN - abort a transfer with ADR status after
//                TIMEOUT_CYC request cycles without ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        icode_i,
    input  logic [2:0]        stat_i,
    input  logic [c_WORD-1:0] valE_i,
    input  logic [c_WORD-1:0] valA_i,
    input  logic [3:0]        dstE_i,
    input  logic [3:0]        dstM_i,
    output logic              stall_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [c_WORD-1:0] dmem_addr,
    output logic [c_WORD-1:0] dmem_wdata,
    input  logic [c_WORD-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid_o,
    output logic [3:0]        wb_icode_o,
    output logic [2:0]        wb_stat_o,
    output logic [c_WORD-1:0] wb_valE_o,
    output logic [c_WORD-1:0] wb_valM_o,
    output logic [3:0]        wb_dstE_o,
    output logic [3:0]        wb_dstM_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_pendIcode;
    logic [c_WORD-1:0] r_pendValE;
    logic [3:0]        r_pendDstE;
    logic [3:0]        r_pendDstM;

    logic              w_isMem;
    logic              w_aok;
    logic [c_WORD-1:0] w_addr;
    logic              w_accept;
    logic              w_timeout;

    logic              w_ld;
    logic [3:0]        w_icode;
    logic [2:0]        w_stat;
    logic [c_WORD-1:0] w_valE;
    logic [c_WORD-1:0] w_valM;
    logic [3:0]        w_dstE;
    logic [3:0]        w_dstM;

    assign w_isMem  = isMemOp(icode_i);
    assign w_aok    = (stat_i == c_SAOK);
    assign w_addr   = addrFromValA(icode_i) ? valA_i : valE_i;
    assign w_accept = (r_state == c_ST_IDLE) && valid_i && w_isMem && w_aok &&
                      (w_addr[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int              c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_waitCnt;

    // Count request cycles; restarts from zero on every new transfer
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_ST_WAIT)) begin
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == c_ST_WAIT) && (r_waitCnt == c_CNT_LAST);
`else
    // TIMEOUT_CYC stays on the interface in every build so instantiations
    // are identical; without the timeout it only feeds this empty check.
    if (TIMEOUT_CYC < 1) begin : g_timeoutCfgUnused
    end

    assign w_timeout = 1'b0;
`endif

    // Select what the MEM/WB register captures this cycle, if anything
    always_comb begin
        w_ld    = 1'b0;
        w_icode = icode_i;
        w_stat  = stat_i;
        w_valE  = valE_i;
        w_valM  = '0;
        w_dstE  = dstE_i;
        w_dstM  = dstM_i;
        case (r_state)
            c_ST_IDLE: begin
                if (valid_i && !w_accept) begin
                    w_ld = 1'b1;
                    // A good-status memory op that was not accepted is misaligned
                    if (w_isMem && w_aok) begin
                        w_stat = c_SADR;
                        w_dstE = c_RNONE;
                        w_dstM = c_RNONE;
                    end
                end
            end
            c_ST_WAIT: begin
                w_icode = r_pendIcode;
                w_stat  = c_SAOK;
                w_valE  = r_pendValE;
                w_dstE  = r_pendDstE;
                w_dstM  = r_pendDstM;
                if (dmem_ack) begin
                    w_ld   = 1'b1;
                    w_valM = dmem_we ? '0 : dmem_rdata;
                end else if (w_timeout) begin
                    w_ld   = 1'b1;
                    w_stat = c_SADR;
                    w_dstM = c_RNONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Hold ex_mem while a transfer is being launched or is outstanding
    always_comb begin
        stall_o = 1'b1;
        case (r_state)
            c_ST_IDLE: stall_o = w_accept;
            c_ST_WAIT: stall_o = !dmem_ack;
            default:   stall_o = 1'b1;
        endcase
    end

    // Stage FSM with registered bus outputs and the pending instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            r_pendIcode <= 4'h0;
            r_pendValE  <= '0;
            r_pendDstE  <= c_RNONE;
            r_pendDstM  <= c_RNONE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= c_ST_WAIT;
                        dmem_req    <= 1'b1;
                        dmem_we     <= !isReadOp(icode_i);
                        dmem_addr   <= w_addr;
                        dmem_wdata  <= valA_i;
                        r_pendIcode <= icode_i;
                        r_pendValE  <= valE_i;
                        r_pendDstE  <= dstE_i;
                        r_pendDstM  <= dstM_i;
                    end else if (w_ld && (w_stat != c_SAOK)) begin
                        r_state <= c_ST_HALT;
                    end
                end
                c_ST_WAIT: begin
                    if (dmem_ack) begin
                        r_state  <= c_ST_IDLE;
                        dmem_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_state  <= c_ST_HALT;
                        dmem_req <= 1'b0;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    mem_wb u_memWb (
        .clk     (clk),
        .rst     (rst),
        .i_ld    (w_ld),
        .i_icode (w_icode),
        .i_stat  (w_stat),
        .i_valE  (w_valE),
        .i_valM  (w_valM),
        .i_dstE  (w_dstE),
        .i_dstM  (w_dstM),
        .o_valid (wb_valid_o),
        .o_icode (wb_icode_o),
        .o_stat  (wb_stat_o),
        .o_valE  (wb_valE_o),
        .o_valM  (wb_valM_o),
        .o_dstE  (wb_dstE_o),
        .o_dstM  (wb_dstM_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed scenarios plus
//                randomized instructions checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  icode_i = '0;
    logic [2:0]  stat_i = 3'd1;
    logic [31:0] valE_i = '0, valA_i = '0;
    logic [3:0]  dstE_i = 4'hF, dstM_i = 4'hF;
    logic        stall_o, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wb_valid_o;
    logic [3:0]  wb_icode_o;
    logic [2:0]  wb_stat_o;
    logic [31:0] wb_valE_o, wb_valM_o;
    logic [3:0]  wb_dstE_o, wb_dstM_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .icode_i(icode_i), .stat_i(stat_i),
        .valE_i(valE_i), .valA_i(valA_i), .dstE_i(dstE_i), .dstM_i(dstM_i),
        .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid_o(wb_valid_o), .wb_icode_o(wb_icode_o),
        .wb_stat_o(wb_stat_o), .wb_valE_o(wb_valE_o), .wb_valM_o(wb_valM_o),
        .wb_dstE_o(wb_dstE_o), .wb_dstM_o(wb_dstM_o)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [31:0] valE, valM;
        logic [3:0]  dstE, dstM;
        int          latency, stallCycles, reqCycles;
        logic [31:0] addr, wdata;
        logic        we, wbValid, released;
    } rec_t;

    // Instruction-level model: what one instruction should produce
    function automatic rec_t refModel(input logic [3:0] ic, input logic [2:0] st,
                                      input logic [31:0] vE, input logic [31:0] vA,
                                      input logic [3:0] dE, input logic [3:0] dM,
                                      input int ackAfter, input logic [31:0] rd);
        rec_t e;
        logic mem, isRead;
        logic [31:0] a;
        mem    = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        isRead = ic inside {4'h5, 4'h9, 4'hB};
        a      = (ic == 4'h9 || ic == 4'hB) ? vA : vE;
        e.icode = ic; e.stat = st; e.valE = vE; e.valM = 32'h0; e.dstE = dE; e.dstM = dM;
        e.latency = 1; e.stallCycles = 0; e.reqCycles = 0;
        e.addr = a; e.wdata = vA; e.we = !isRead; e.wbValid = 1'b1; e.released = 1'b1;
        if (mem && st == 3'd1) begin
            if (a[1:0] != 2'b00) begin
                e.stat = 3'd3; e.dstE = 4'hF; e.dstM = 4'hF;
            end else begin
                e.latency     = ackAfter + 2;
                e.stallCycles = ackAfter + 1;
                e.reqCycles   = ackAfter + 1;
                if (isRead) e.valM = rd;
            end
        end
        return e;
    endfunction

    // Present one instruction, ack on request cycle ackAfter (-1: never),
    // and gather what the DUT did; wb_* sampled one cycle after release.
    task automatic runOp(input logic [3:0] ic, input logic [2:0] st,
                         input logic [31:0] vE, input logic [31:0] vA,
                         input logic [3:0] dE, input logic [3:0] dM,
                         input int ackAfter, input logic [31:0] rd, output rec_t o);
        o.latency = 0; o.stallCycles = 0; o.reqCycles = 0; o.released = 1'b0;
        o.addr = '0; o.wdata = '0; o.we = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b1; icode_i = ic; stat_i = st; valE_i = vE; valA_i = vA;
        dstE_i = dE; dstM_i = dM;
        for (int k = 0; k < 40 && !o.released; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            dmem_ack   = dmem_req && (o.reqCycles == ackAfter);
            dmem_rdata = dmem_ack ? rd : $urandom;
            @(negedge clk);
            if (stall_o) o.stallCycles++;
            if (dmem_req) begin
                if (o.reqCycles == 0) begin
                    o.addr = dmem_addr; o.we = dmem_we; o.wdata = dmem_wdata;
                end
                o.reqCycles++;
            end
            if (!stall_o) begin o.released = 1'b1; o.latency = k + 1; end
        end
        @(posedge clk); #1;
        valid_i = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        o.wbValid = wb_valid_o; o.icode = wb_icode_o; o.stat = wb_stat_o;
        o.valE = wb_valE_o; o.valM = wb_valM_o; o.dstE = wb_dstE_o; o.dstM = wb_dstM_o;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; valid_i = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clk);
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset wb_valid: got %0h exp 0", wb_valid_o); end
        checks++; if (wb_stat_o !== 3'd1) begin errors++; $display("FAIL reset wb_stat: got %0h exp 1", wb_stat_o); end
        checks++; if (wb_dstE_o !== 4'hF || wb_dstM_o !== 4'hF) begin errors++; $display("FAIL reset wb_dst: got %0h/%0h exp f/f", wb_dstE_o, wb_dstM_o); end
        checks++; if (wb_valE_o !== 32'h0 || wb_valM_o !== 32'h0 || wb_icode_o !== 4'h0) begin errors++; $display("FAIL reset wb_data: got %0h/%0h/%0h exp 0", wb_valE_o, wb_valM_o, wb_icode_o); end
        checks++; if (dmem_req !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL reset bus: req %0h stall %0h exp 0/0", dmem_req, stall_o); end
    endtask

    // Non-memory, load and store directed cases plus a randomized mix
    task automatic test_ops(input string name, input int n, input bit randomize,
                            input logic [3:0] ic0, input logic [31:0] vE0, input logic [31:0] vA0,
                            input logic [3:0] dE0, input logic [3:0] dM0, input int ack0,
                            input logic [31:0] rd0);
        rec_t o, e;
        logic [3:0] ic, dE, dM; logic [31:0] vE, vA, rd; int ackAfter; logic mem;
        for (int i = 0; i < n; i++) begin
            ic = ic0; vE = vE0; vA = vA0; dE = dE0; dM = dM0; ackAfter = ack0; rd = rd0;
            if (randomize) begin
                ic = 4'($urandom_range(0, 11)); vE = $urandom; vA = $urandom;
                dE = 4'($urandom); dM = 4'($urandom); ackAfter = $urandom_range(0, 3); rd = $urandom;
                mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
                if (mem) begin vE[1:0] = 2'b00; vA[1:0] = 2'b00; end
            end
            e = refModel(ic, 3'd1, vE, vA, dE, dM, ackAfter, rd);
            runOp(ic, 3'd1, vE, vA, dE, dM, ackAfter, rd, o);
            checks++; if (o.latency !== e.latency) begin errors++; $display("FAIL %s%0d latency: got %0d exp %0d", name, i, o.latency, e.latency); end
            checks++; if (o.stallCycles !== e.stallCycles) begin errors++; $display("FAIL %s%0d stall cycles: got %0d exp %0d", name, i, o.stallCycles, e.stallCycles); end
            checks++; if (o.reqCycles !== e.reqCycles) begin errors++; $display("FAIL %s%0d req cycles: got %0d exp %0d", name, i, o.reqCycles, e.reqCycles); end
            checks++; if (o.wbValid !== 1'b1 || o.icode !== e.icode || o.stat !== e.stat) begin errors++; $display("FAIL %s%0d wb v/icode/stat: got %0h/%0h/%0h exp 1/%0h/%0h", name, i, o.wbValid, o.icode, o.stat, e.icode, e.stat); end
            checks++; if (o.valE !== e.valE || o.valM !== e.valM) begin errors++; $display("FAIL %s%0d wb valE/valM: got %0h/%0h exp %0h/%0h", name, i, o.valE, o.valM, e.valE, e.valM); end
            checks++; if (o.dstE !== e.dstE || o.dstM !== e.dstM) begin errors++; $display("FAIL %s%0d wb dstE/dstM: got %0h/%0h exp %0h/%0h", name, i, o.dstE, o.dstM, e.dstE, e.dstM); end
            if (e.reqCycles > 0) begin
                checks++; if (o.addr !== e.addr || o.we !== e.we) begin errors++; $display("FAIL %s%0d bus addr/we: got %0h/%0h exp %0h/%0h", name, i, o.addr, o.we, e.addr, e.we); end
                if (e.we) begin
                    checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL %s%0d bus wdata: got %0h exp %0h", name, i, o.wdata, e.wdata); end
                end
            end
        end
        @(negedge clk);
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL %s wb_valid after pulse: got %0h exp 0", name, wb_valid_o); end
    endtask

    // An ack while idle must not start or complete anything
    task automatic test_stray_ack();
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (dmem_req !== 1'b0 || wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL stray ack: req %0h wbv %0h stall %0h exp 0/0/0", dmem_req, wb_valid_o, stall_o); end
        end
        @(posedge clk); #1 dmem_ack = 1'b0;
    endtask

    // Check the frozen state: stall high, no bus, no results despite valid_i
    task automatic checkHalted(input string name);
        @(posedge clk); #1;
        valid_i = 1'b1; icode_i = 4'h5; stat_i = 3'd1; valE_i = 32'h40;
        repeat (4) begin
            @(negedge clk);
            checks++; if (stall_o !== 1'b1 || dmem_req !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL %s halted: stall %0h req %0h wbv %0h exp 1/0/0", name, stall_o, dmem_req, wb_valid_o); end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic test_misaligned();
        rec_t o;
        runOp(4'hA, 3'd1, 32'h102, 32'h7, 4'h4, 4'hF, 0, 32'h0, o);
        checks++; if (o.reqCycles !== 0 || o.latency !== 1) begin errors++; $display("FAIL misaligned req/lat: got %0d/%0d exp 0/1", o.reqCycles, o.latency); end
        checks++; if (o.stat !== 3'd3 || o.dstE !== 4'hF || o.dstM !== 4'hF) begin errors++; $display("FAIL misaligned wb stat/dst: got %0h/%0h/%0h exp 3/f/f", o.stat, o.dstE, o.dstM); end
        checkHalted("misaligned");
    endtask

    task automatic test_halt_reset();
        rec_t o;
        doReset();
        runOp(4'h0, 3'd2, 32'h0, 32'h0, 4'hF, 4'hF, 0, 32'h0, o);
        checks++; if (o.stat !== 3'd2 || o.wbValid !== 1'b1) begin errors++; $display("FAIL halt passthrough: stat %0h valid %0h exp 2/1", o.stat, o.wbValid); end
        checkHalted("hlt");
        doReset();
        @(negedge clk);
        checks++; if (wb_stat_o !== 3'd1 || wb_dstE_o !== 4'hF || stall_o !== 1'b0) begin errors++; $display("FAIL halt reset: stat %0h dstE %0h stall %0h exp 1/f/0", wb_stat_o, wb_dstE_o, stall_o); end
        test_ops("afterhalt", 1, 1'b0, 4'h3, 32'h55, 32'h0, 4'h1, 4'hF, 0, 32'h0);
        // Reset during an open transfer drops the request at the next edge
        @(posedge clk); #1;
        valid_i = 1'b1; icode_i = 4'h5; stat_i = 3'd1; valE_i = 32'h300; dstM_i = 4'h2;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst-in-wait pre: req %0h exp 1", dmem_req); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst-in-wait: req %0h stall %0h wbv %0h exp 0/0/0", dmem_req, stall_o, wb_valid_o); end
    endtask

    task automatic test_timeout();
        int reqs;
        logic sawAdr;
        doReset();
        @(posedge clk); #1;
        valid_i = 1'b1; icode_i = 4'h5; stat_i = 3'd1; valE_i = 32'h200; dstE_i = 4'hF; dstM_i = 4'h6;
        reqs = 0; sawAdr = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dmem_req) reqs++;
            if (wb_valid_o && wb_stat_o == 3'd3 && wb_dstM_o == 4'hF) sawAdr = 1'b1;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        checks++; if (reqs !== TO) begin errors++; $display("FAIL timeout req cycles: got %0d exp %0d", reqs, TO); end
        checks++; if (sawAdr !== 1'b1) begin errors++; $display("FAIL timeout ADR result: got %0h exp 1", sawAdr); end
        checkHalted("timeout");
`else
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if (dmem_req) reqs++;
            if (wb_valid_o) sawAdr = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (reqs !== 20 || sawAdr !== 1'b0) begin errors++; $display("FAIL no-timeout wait: req %0d wbv %0h exp 20/0", reqs, sawAdr); end
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(posedge clk); #1;
        dmem_ack = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        checks++; if (wb_valid_o !== 1'b1 || wb_valM_o !== 32'h12345678 || wb_dstM_o !== 4'h6 || wb_stat_o !== 3'd1) begin errors++; $display("FAIL no-timeout ack: v %0h valM %0h dstM %0h stat %0h exp 1/12345678/6/1", wb_valid_o, wb_valM_o, wb_dstM_o, wb_stat_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_ops("nonmem", 1, 1'b0, 4'h3, 32'h42, 32'h0, 4'h2, 4'hF, 0, 32'h0);
        test_ops("load", 1, 1'b0, 4'h5, 32'h100, 32'h0, 4'hF, 4'h3, 3, 32'hDEADBEEF);
        test_ops("store", 1, 1'b0, 4'h8, 32'h1FC, 32'h20, 4'h4, 4'hF, 0, 32'h0);
        test_stray_ack();
        test_ops("rnd", 30, 1'b1, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 32'h0);
        test_misaligned();
        test_halt_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
